// File: rtl/uart_pkg.sv
// Shared definitions for the serial block: FSM state encoding, counter width
// and the clocks-per-bit helper also used by the transmitter.
package uart_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    function automatic int uart_cycles(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake: the receiver (master) offers bytes and error
// pulses, the consumer (slave) answers with ready.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport master (
        output rx_data,
        output rx_data_valid,
        output rx_frame_err,
        output rx_overrun,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_data_ready
    );

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector that
// only arms once the synchronizer holds real line samples.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall_pulse
);

    logic       meta_reg;
    logic       sync_reg;
    logic       hist_reg;
    logic [1:0] prime_reg;

    // The history flop stays 0 until the reset value of sync_reg has been
    // flushed out, so a line that is already low at reset release never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg  <= 1'b1;
            sync_reg  <= 1'b1;
            hist_reg  <= 1'b0;
            prime_reg <= 2'b00;
        end else begin
            meta_reg  <= async_in;
            sync_reg  <= meta_reg;
            prime_reg <= {prime_reg[0], 1'b1};
            hist_reg  <= sync_reg & prime_reg[1];
        end
    end

    assign sync_out   = sync_reg;
    assign fall_pulse = ~sync_reg & hist_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: mid-bit sampling, byte offered on a
// valid/ready handshake, framing error and overrun reported as pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_pin,
    uart_rx_if.master rx
);

    localparam int CYCLE = uart_cycles(CLK_FRE, BAUD_RATE);
    localparam int HALF  = CYCLE / 2;
    localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);

    generate
        if (CYCLE < 4 || CYCLE > 65535) begin : g_cycle_range
            $error("uart_rx: clocks per bit must lie in 4..65535");
        end
    endgenerate

    logic rx_s;
    logic fall_pulse;

    uart_sync_edge u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (rx_pin),
        .sync_out   (rx_s),
        .fall_pulse (fall_pulse)
    );

    uart_state_t      state_reg,     state_next;
    logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
    logic [2:0]       bit_cnt_reg,   bit_cnt_next;
    logic [7:0]       shreg_reg,     shreg_next;
    logic [7:0]       data_reg,      data_next;
    logic             valid_reg,     valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg,   overrun_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cycle_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cycle_cnt_reg <= cycle_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shreg_reg     <= shreg_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cycle_cnt_next = cycle_cnt_reg + 1'b1;
        bit_cnt_next   = bit_cnt_reg;
        shreg_next     = shreg_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        // A completion in the same cycle overrides this and reloads the byte.
        if (valid_reg && rx.rx_data_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                cycle_cnt_next = '0;
                bit_cnt_next   = '0;
                if (fall_pulse) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cycle_cnt_reg == HALF_LAST) begin
                    cycle_cnt_next = '0;
                    state_next     = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cycle_cnt_reg == CYCLE_LAST) begin
                    cycle_cnt_next          = '0;
                    shreg_next[bit_cnt_reg] = rx_s;
                    bit_cnt_next            = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a following start edge is not missed.
                if (cycle_cnt_reg == CYCLE_LAST) begin
                    cycle_cnt_next = '0;
                    state_next     = S_IDLE;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
                    end else if (valid_reg && !rx.rx_data_ready) begin
                        overrun_next = 1'b1;
                    end else begin
                        data_next  = shreg_reg;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = S_IDLE;
                cycle_cnt_next = '0;
            end
        endcase
    end

    assign rx.rx_data       = data_reg;
    assign rx.rx_data_valid = valid_reg;
    assign rx.rx_frame_err  = frame_err_reg;
    assign rx.rx_overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (234 clocks per bit).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_T   = 234;
    localparam int LATENCY = 2 + 1 + 117 + 9 * 234;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rx_pin = 1'b1;

    uart_rx_if rx_bus ();

    uart_rx #(
        .CLK_FRE   (27),
        .BAUD_RATE (115200)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_pin (rx_pin),
        .rx     (rx_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cyc      = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         acc_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] acc_bytes [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= rx_bus.rx_data_valid;
        if (rx_bus.rx_data_valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (rx_bus.rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_bus.rx_overrun)   ov_cnt <= ov_cnt + 1;
        if (rx_bus.rx_data_valid && rx_bus.rx_data_ready) begin
            if (acc_cnt < 64) acc_bytes[acc_cnt] <= rx_bus.rx_data;
            acc_cnt <= acc_cnt + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising clock edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_pin = v;
        wait_cycles(BIT_T);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        wait_cycles(3);
        checks++;
        if (rx_bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", rx_bus.rx_data);
        end
        checks++;
        if (rx_bus.rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", rx_bus.rx_data_valid);
        end
        checks++;
        if (rx_bus.rx_frame_err !== 1'b0 || rx_bus.rx_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0",
                               rx_bus.rx_frame_err, rx_bus.rx_overrun);
        end
        checks++;
        if (dut.state_reg !== S_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, S_IDLE);
        end
        rst_n = 1'b1;
        wait_cycles(10);
        $display("test_reset done");
    endtask

    task automatic test_single;
        int k, r0, a0, f0, o0;
        rx_bus.rx_data_ready = 1'b1;
        r0 = rise_cnt; a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        k = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cycles(BIT_T);
        checks++;
        if (rise_cnt - r0 !== 1 || acc_cnt - a0 !== 1) begin
            errors++; $display("FAIL single_count: got rises=%0d accepts=%0d want 1 1",
                               rise_cnt - r0, acc_cnt - a0);
        end
        checks++;
        if (acc_bytes[a0] !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h want a5", acc_bytes[a0]);
        end
        checks++;
        if (rise_cyc - k < LATENCY - 1 || rise_cyc - k > LATENCY + 1) begin
            errors++; $display("FAIL single_latency: got %0d want %0d+-1", rise_cyc - k, LATENCY);
        end
        checks++;
        if (rx_bus.rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid_drop: got %b want 0", rx_bus.rx_data_valid);
        end
        checks++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0",
                               fe_cnt - f0, ov_cnt - o0);
        end
        $display("test_single: frame a5 latency %0d", rise_cyc - k);
    endtask

    task automatic test_back_to_back;
        int a0, r0, f0, o0;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        rx_bus.rx_data_ready = 1'b1;
        a0 = acc_cnt; r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        wait_cycles(2 * BIT_T);
        checks++;
        if (acc_cnt - a0 !== 3 || rise_cnt - r0 !== 3) begin
            errors++; $display("FAIL b2b_count: got accepts=%0d rises=%0d want 3 3",
                               acc_cnt - a0, rise_cnt - r0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_bytes[a0 + i] !== exp_b[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", i, acc_bytes[a0 + i], exp_b[i]);
            end
        end
        checks++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL b2b_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0);
        end
        $display("test_back_to_back: 3 frames sent, %0d accepted", acc_cnt - a0);
    endtask

    task automatic test_glitch;
        int r0, f0, o0;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        rx_pin = 1'b0;
        wait_cycles(50);
        rx_pin = 1'b1;
        wait_cycles(10);
        checks++;
        if (dut.state_reg !== S_START) begin
            errors++; $display("FAIL glitch_seen: got state %0d want %0d", dut.state_reg, S_START);
        end
        wait_cycles(65);
        checks++;
        if (dut.state_reg !== S_IDLE) begin
            errors++; $display("FAIL glitch_idle: got state %0d want %0d", dut.state_reg, S_IDLE);
        end
        wait_cycles(3 * BIT_T);
        checks++;
        if (rise_cnt - r0 !== 0 || fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL glitch_quiet: got rises=%0d fe=%0d ov=%0d want 0 0 0",
                               rise_cnt - r0, fe_cnt - f0, ov_cnt - o0);
        end
        $display("test_glitch: 50-clk low pulse ignored");
    endtask

    task automatic test_frame_err;
        int r0, f0, a0;
        rx_bus.rx_data_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_cnt - f0);
        end
        wait_cycles(20 * BIT_T);
        rx_pin = 1'b1;
        wait_cycles(2 * BIT_T);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++; $display("FAIL ferr_break: got %0d pulses want 1", fe_cnt - f0);
        end
        checks++;
        if (rise_cnt - r0 !== 0) begin
            errors++; $display("FAIL ferr_no_valid: got %0d valid rises want 0", rise_cnt - r0);
        end
        a0 = acc_cnt;
        send_frame(8'h5A, 1'b1);
        wait_cycles(BIT_T);
        checks++;
        if (acc_cnt - a0 !== 1 || acc_bytes[a0] !== 8'h5A) begin
            errors++; $display("FAIL ferr_recover: got accepts=%0d byte=%h want 1 5a",
                               acc_cnt - a0, acc_bytes[a0]);
        end
        $display("test_frame_err: %0d frame error pulse(s)", fe_cnt - f0);
    endtask

    task automatic test_overrun;
        int o0, a0, f0;
        rx_bus.rx_data_ready = 1'b0;
        o0 = ov_cnt; a0 = acc_cnt; f0 = fe_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(2 * BIT_T);
        checks++;
        if (rx_bus.rx_data_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_valid: got %b want 1", rx_bus.rx_data_valid);
        end
        checks++;
        if (rx_bus.rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_data: got %h want 11", rx_bus.rx_data);
        end
        checks++;
        if (ov_cnt - o0 !== 1 || fe_cnt - f0 !== 0) begin
            errors++; $display("FAIL ovr_pulse: got ov=%0d fe=%0d want 1 0", ov_cnt - o0, fe_cnt - f0);
        end
        rx_bus.rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_bus.rx_data_ready = 1'b0;
        wait_cycles(2);
        checks++;
        if (rx_bus.rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_accept: got valid %b want 0", rx_bus.rx_data_valid);
        end
        checks++;
        if (acc_cnt - a0 !== 1 || acc_bytes[a0] !== 8'h11) begin
            errors++; $display("FAIL ovr_accepted: got accepts=%0d byte=%h want 1 11",
                               acc_cnt - a0, acc_bytes[a0]);
        end
        $display("test_overrun: %0d overrun pulse(s)", ov_cnt - o0);
    endtask

    task automatic test_reset_midframe;
        int r0, f0, o0, a0;
        logic [7:0] b;
        b = 8'h81;
        rx_bus.rx_data_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_pin = b[4];
        wait_cycles(100);
        rst_n = 1'b0;
        wait_cycles(3);
        checks++;
        if (rx_bus.rx_data !== 8'h00 || rx_bus.rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: got data=%h valid=%b want 00 0",
                               rx_bus.rx_data, rx_bus.rx_data_valid);
        end
        rst_n = 1'b1;
        wait_cycles(BIT_T - 103);
        for (int i = 5; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        wait_cycles(3 * BIT_T);
        checks++;
        if (rise_cnt - r0 !== 0 || fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL midrst_quiet: got rises=%0d fe=%0d ov=%0d want 0 0 0",
                               rise_cnt - r0, fe_cnt - f0, ov_cnt - o0);
        end
        checks++;
        if (dut.state_reg !== S_IDLE) begin
            errors++; $display("FAIL midrst_idle: got state %0d want %0d", dut.state_reg, S_IDLE);
        end
        a0 = acc_cnt;
        send_frame(8'h81, 1'b1);
        wait_cycles(BIT_T);
        checks++;
        if (acc_cnt - a0 !== 1 || acc_bytes[a0] !== 8'h81) begin
            errors++; $display("FAIL midrst_next: got accepts=%0d byte=%h want 1 81",
                               acc_cnt - a0, acc_bytes[a0]);
        end
        checks++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL midrst_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0);
        end
        $display("test_reset_midframe: follow-up frame accepted");
    endtask

    initial begin
        rx_bus.rx_data_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
